// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter among N_REQ byte requesters.
// Optional macro UART_TX_ARB_LOCK_EN adds req_last so a requester can hold the line for a multi-byte message.
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int CLOCKS_PER_BIT = 10417,
    parameter int GUARD_CYCLES   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
`ifdef UART_TX_ARB_LOCK_EN
    input  logic [N_REQ-1:0]              req_last,
`endif
    output logic [N_REQ-1:0]              req_ready,
    output logic                          tx_wr_en,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_new_txn,
    output logic                          busy,
    output logic [$clog2(N_REQ)-1:0]      owner
);

    localparam int FRAME_CYCLES = (DATA_WIDTH + 2) * CLOCKS_PER_BIT + GUARD_CYCLES;
    localparam int PTR_W        = $clog2(N_REQ);
    localparam int CNT_W        = $clog2(FRAME_CYCLES + 1);

    typedef enum logic [1:0] {
        S_ARB  = 2'd0,
        S_LOAD = 2'd1,
        S_KICK = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t                  state_r;
    logic [PTR_W-1:0]        ptr_r;
    logic [PTR_W-1:0]        owner_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [DATA_WIDTH-1:0]   tx_data_r;
    logic                    tx_wr_en_r;
    logic                    tx_new_txn_r;
    logic                    busy_r;
    logic                    locked_r;

    logic                    rr_found_s;
    logic [PTR_W-1:0]        rr_winner_s;
    logic                    found_s;
    logic [PTR_W-1:0]        winner_s;
    logic                    grant_s;
    logic                    last_s;
    logic [DATA_WIDTH-1:0]   win_data_s;
    logic [PTR_W:0]          sum_v;
    logic [PTR_W-1:0]        idx_v;

    // Round-robin scan starting just above the pointer, wrapping modulo N_REQ.
    always_comb begin
        rr_found_s  = 1'b0;
        rr_winner_s = '0;
        sum_v       = '0;
        idx_v       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            sum_v = {1'b0, ptr_r} + (PTR_W + 1)'(k);
            idx_v = PTR_W'((sum_v >= (PTR_W + 1)'(N_REQ)) ? (sum_v - (PTR_W + 1)'(N_REQ)) : sum_v);
            if (!rr_found_s && req_valid[idx_v]) begin
                rr_found_s  = 1'b1;
                rr_winner_s = idx_v;
            end else begin
                rr_found_s  = rr_found_s;
                rr_winner_s = rr_winner_s;
            end
        end
    end

    // A held lock restricts arbitration to the current owner only.
    always_comb begin
        found_s  = rr_found_s;
        winner_s = rr_winner_s;
        last_s   = 1'b1;
`ifdef UART_TX_ARB_LOCK_EN
        if (locked_r) begin
            found_s  = req_valid[owner_r];
            winner_s = owner_r;
        end else begin
            found_s  = rr_found_s;
            winner_s = rr_winner_s;
        end
        last_s = req_last[winner_s];
`endif
    end

    // Grant decode and winner byte selection.
    always_comb begin
        grant_s    = (state_r == S_ARB) && found_s;
        win_data_s = req_data[int'(winner_s) * DATA_WIDTH +: DATA_WIDTH];
        if (grant_s) begin
            req_ready = {{(N_REQ - 1){1'b0}}, 1'b1} << winner_s;
        end else begin
            req_ready = '0;
        end
    end

    // Main sequencer: ARB -> LOAD -> KICK -> WAIT, with registered transmitter controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_ARB;
            ptr_r        <= PTR_W'(N_REQ - 1);
            owner_r      <= '0;
            cnt_r        <= '0;
            tx_data_r    <= '0;
            tx_wr_en_r   <= 1'b0;
            tx_new_txn_r <= 1'b0;
            busy_r       <= 1'b0;
            locked_r     <= 1'b0;
        end else begin
            case (state_r)
                S_ARB: begin
                    if (grant_s) begin
                        ptr_r      <= winner_s;
                        owner_r    <= winner_s;
                        tx_data_r  <= win_data_s;
                        tx_wr_en_r <= 1'b1;
                        busy_r     <= 1'b1;
                        locked_r   <= ~last_s;
                        state_r    <= S_LOAD;
                    end else begin
                        state_r    <= S_ARB;
                    end
                end
                S_LOAD: begin
                    tx_wr_en_r   <= 1'b0;
                    tx_new_txn_r <= 1'b1;
                    state_r      <= S_KICK;
                end
                S_KICK: begin
                    tx_new_txn_r <= 1'b0;
                    cnt_r        <= CNT_W'(FRAME_CYCLES - 1);
                    state_r      <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_r == '0) begin
                        busy_r  <= 1'b0;
                        state_r <= S_ARB;
                    end else begin
                        cnt_r   <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    tx_wr_en_r   <= 1'b0;
                    tx_new_txn_r <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= S_ARB;
                end
            endcase
        end
    end

    assign tx_wr_en   = tx_wr_en_r;
    assign tx_new_txn = tx_new_txn_r;
    assign tx_data    = tx_data_r;
    assign busy       = busy_r;
    assign owner      = owner_r;

    uart_tx_arbiter_chk #(.N_REQ(N_REQ)) u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_ready  (req_ready),
        .tx_wr_en   (tx_wr_en),
        .tx_new_txn (tx_new_txn),
        .busy       (busy)
    );

endmodule

// Protocol invariants of the arbiter outputs.
module uart_tx_arbiter_chk #(
    parameter int N_REQ = 4
) (
    input logic             clk,
    input logic             rst_n,
    input logic [N_REQ-1:0] req_ready,
    input logic             tx_wr_en,
    input logic             tx_new_txn,
    input logic             busy
);

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
    a_ready_idle:   assert property (@(posedge clk) disable iff (!rst_n) (|req_ready) |-> !busy);
    a_wr_kick_excl: assert property (@(posedge clk) disable iff (!rst_n) !(tx_wr_en && tx_new_txn));
    a_wr_busy:      assert property (@(posedge clk) disable iff (!rst_n) tx_wr_en |-> busy);

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (8N1, `wrEn`/`dataIn`/`newTXN` load-and-kick interface, no busy output) between N_REQ byte requesters.
- Round-robin arbitration; loads the winner's byte and kicks the transmitter.
- Self-times the frame with a hold-off counter before the next grant.
- Sits between the protocol clients (debug console, status reporter, etc.) and the UART TX instance.

Parameters:
- N_REQ, 4: number of requesters; legal range 2..16.
- DATA_WIDTH, 8: byte width; must match the transmitter.
- CLOCKS_PER_BIT, 10417: clock cycles per bit (100 MHz / 9600 baud); must match the transmitter.
- GUARD_CYCLES, 4: extra idle cycles appended after each frame.
- FRAME_CYCLES, (DATA_WIDTH+2)*CLOCKS_PER_BIT+GUARD_CYCLES: hold-off length. Derived localparam, not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  N_REQ  per-requester byte available.
- req_data  input  N_REQ*DATA_WIDTH  packed bytes; requester i owns bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  N_REQ  one-hot accept strobe.
- tx_wr_en  output  1  to transmitter `wrEn`.
- tx_data  output  DATA_WIDTH  to transmitter `dataIn`.
- tx_new_txn  output  1  to transmitter `newTXN`.
- busy  output  1  frame in progress.
- owner  output  $clog2(N_REQ)  index of last granted requester.

Behaviour:
- Reset (async assert, sync deassert expected upstream):
  - All outputs 0; state ARB; hold-off counter 0.
  - RR pointer = N_REQ-1, so requester 0 has first priority.
  - A frame already on the wire is abandoned; the arbiter does not wait for it.
- State ARB:
  - busy=0.
  - Winner = first set bit of req_valid scanning from pointer+1 upward, wrapping modulo N_REQ.
  - req_ready[winner] asserted combinationally in the same cycle; all other ready bits 0.
  - Handshake completes when valid & ready in one cycle; data is sampled that cycle into an internal register.
  - On handshake: pointer and owner <= winner; go to LOAD.
  - If no valid, stay in ARB.
- State LOAD:
  - One cycle; tx_wr_en=1; tx_data=captured byte; busy=1.
  - Next state KICK.
- State KICK:
  - One cycle; tx_new_txn=1; tx_data held; busy=1.
  - Counter <= FRAME_CYCLES-1; next state WAIT.
- State WAIT:
  - busy=1; counter decrements each cycle.
  - At counter==0, go to ARB.
- Outside LOAD, tx_wr_en=0; outside KICK, tx_new_txn=0; tx_data holds its last value.
- req_ready is 0 in all states except ARB; requests arriving during LOAD/KICK/WAIT wait their turn.
- A requester may drop req_valid before being granted, with no side effect.
- Latency:
  - Handshake at cycle t -> tx_wr_en at t+1 -> tx_new_txn at t+2.
  - Earliest next handshake at t+3+FRAME_CYCLES.
- Counter width is $clog2(FRAME_CYCLES+1); no wrap.
- Single requester continuously valid: granted every frame slot.
- All requesters valid: strict rotation 0,1,2,3,0,...

Optional Feature:
- Macro: UART_TX_ARB_LOCK_EN.
- Defined:
  - Adds input req_last (N_REQ).
  - After a grant whose req_last[owner]=0, ARB considers only owner; other requesters are blocked until owner hands off a byte with req_last=1.
  - Pointer still updates to owner; a lock persists across idle cycles.
- Undefined:
  - Port req_last is absent.
  - Arbitration is re-run after every frame.

Test Plan (CLOCKS_PER_BIT=4, DATA_WIDTH=8, N_REQ=4 -> FRAME_CYCLES=44):
- Reset then req_valid=4'b0001, data0=8'hA5 -> req_ready=0001 same cycle; tx_wr_en with tx_data=A5 next cycle; tx_new_txn one cycle later; busy high for 46 cycles total; owner=0.
- req_valid=4'b1111 held, bytes 11/22/33/44 -> grant order 0,1,2,3,0; consecutive handshakes 47 cycles apart.
- During WAIT, raise req_valid[2] -> req_ready stays 0 until ARB; then granted in the first ARB cycle.
- Assert rst_n=0 mid-WAIT -> all outputs 0 immediately; after release, requester 0 is granted first.
- req_valid[1] pulses 1 cycle while busy, then drops -> never granted; no tx_wr_en.
- LOCK_EN: requester 1 sends 3 bytes, req_last=0,0,1, while requester 0 is valid throughout -> order 1,1,1,0.
